bist_seq_controller: RTL and testbench

- Parametrised successor of the single-channel BIST controller.
- Runs a BIST session over up to NUM_CH channels in sequence. Each enabled channel gets one INIT cycle, then a run-time programmable number of RUN cycles with a toggle stimulus.
- Supports abort and continuous (loop) mode; reports a sticky end flag and a pass counter.
- Sits between the test-access logic (start, abort, config) and the per-channel pattern generators and signature checkers.

---
 rtl/bist_seq_controller.sv | 134 +++++++++++++
 tb/tb_bist_seq_controller.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bist_seq_controller.sv
// rtl/bist_seq_controller.sv - multi-channel BIST session sequencer with abort and loop modes
module bist_seq_controller #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int PASS_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              loop,
  input  logic [CNT_W-1:0]  ncycles,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic              busy,
  output logic              init,
  output logic              running,
  output logic              toggle,
  output logic              finish,
  output logic [NUM_CH-1:0] ch_sel,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [PASS_W-1:0] pass_cnt,
  output logic              aborted,
  output logic              bist_end
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEL    = 3'd1,
    ST_INIT   = 3'd2,
    ST_RUN    = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  state_t            state, state_nx;
  logic              start_d;
  logic [CNT_W-1:0]  ncycles_q;
  logic [NUM_CH-1:0] mask_q;
  logic [NUM_CH-1:0] rem_mask;
  logic [NUM_CH-1:0] ch_sel_q;
  logic [NUM_CH-1:0] low_bit;
  logic              toggle_r;
  logic              accept;
  logic              abort_hit;
  logic              last_run;

  // Lowest pending channel: isolate the least significant set bit.
  assign low_bit  = rem_mask & (~rem_mask + NUM_CH'(1));
  assign last_run = (cycle_cnt == ncycles_q - CNT_W'(1));

  // State register; start_d comes up high so a start held through reset is not an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state decode; abort overrides every transition out of SEL/INIT/RUN.
  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    abort_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !start_d) begin
          accept   = 1'b1;
          state_nx = ST_SEL;
        end
      end
      ST_SEL:    state_nx = (rem_mask != '0) ? ST_INIT : ST_FINISH;
      ST_INIT:   state_nx = (ncycles_q == '0) ? ST_SEL : ST_RUN;
      ST_RUN:    if (last_run) state_nx = ST_SEL;
      ST_FINISH: state_nx = (loop && !aborted) ? ST_SEL : ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
    if (abort && (state == ST_SEL || state == ST_INIT || state == ST_RUN)) begin
      abort_hit = 1'b1;
      state_nx  = ST_FINISH;
    end
  end

  // Session datapath: latched config, channel walk, run counter, pass count and sticky flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_d   <= 1'b1;
      ncycles_q <= '0;
      mask_q    <= '0;
      rem_mask  <= '0;
      ch_sel_q  <= '0;
      cycle_cnt <= '0;
      toggle_r  <= 1'b0;
      pass_cnt  <= '0;
      aborted   <= 1'b0;
      bist_end  <= 1'b0;
    end else begin
      start_d <= start;
      if (accept) begin
        ncycles_q <= ncycles;
        mask_q    <= ch_mask;
        rem_mask  <= ch_mask;
        pass_cnt  <= '0;
        aborted   <= 1'b0;
        bist_end  <= 1'b0;
      end
      if (abort_hit) aborted <= 1'b1;
      case (state)
        ST_SEL: begin
          ch_sel_q <= low_bit;
          rem_mask <= rem_mask & ~low_bit;
        end
        ST_INIT: begin
          cycle_cnt <= '0;
          toggle_r  <= 1'b0;
        end
        ST_RUN: begin
          cycle_cnt <= cycle_cnt + CNT_W'(1);
          toggle_r  <= ~toggle_r;
        end
        ST_FINISH: begin
          if (!aborted) pass_cnt <= pass_cnt + PASS_W'(1);
          if (loop && !aborted) rem_mask <= mask_q;
          else                  bist_end <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state != ST_IDLE);
  assign init    = (state == ST_INIT);
  assign running = (state == ST_RUN);
  assign finish  = (state == ST_FINISH);
  assign toggle  = running & ~toggle_r;
  assign ch_sel  = (init || running) ? ch_sel_q : '0;

endmodule

// File: tb/tb_bist_seq_controller.sv
// tb/tb_bist_seq_controller.sv - scoreboard bench for bist_seq_controller
module tb_bist_seq_controller;

  localparam int K_IDLE = 0, K_SEL = 1, K_INIT = 2, K_RUN = 3, K_FIN = 4;

  typedef struct {
    int          kind;
    logic [25:0] vec;
  } item_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b1;
  logic        abort = 1'b0;
  logic        loop = 1'b0;
  logic [15:0] ncycles = '0;
  logic [3:0]  ch_mask = '0;
  logic        busy, init, running, toggle, finish;
  logic [3:0]  ch_sel;
  logic [15:0] cycle_cnt;
  logic [7:0]  pass_cnt;
  logic        aborted, bist_end;

  item_t sb[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc;

  bist_seq_controller dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .loop(loop),
    .ncycles(ncycles), .ch_mask(ch_mask), .busy(busy), .init(init),
    .running(running), .toggle(toggle), .finish(finish), .ch_sel(ch_sel),
    .cycle_cnt(cycle_cnt), .pass_cnt(pass_cnt), .aborted(aborted), .bist_end(bist_end)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Observed status; cycle_cnt only matters while running.
  function automatic logic [25:0] obs();
    return {bist_end, busy, init, running, toggle, finish, ch_sel,
            running ? cycle_cnt : 16'h0};
  endfunction

  function automatic logic [25:0] mk(input int kind, input int ch, input int k);
    logic [3:0]  sel;
    logic [15:0] cnt;
    sel = (kind == K_INIT || kind == K_RUN) ? 4'(1 << ch) : 4'h0;
    cnt = (kind == K_RUN) ? 16'(k) : 16'h0;
    return {1'b0, kind != K_IDLE, kind == K_INIT, kind == K_RUN,
            (kind == K_RUN) && (k % 2 == 0), kind == K_FIN, sel, cnt};
  endfunction

  task automatic push(input int kind, input int ch, input int k);
    item_t it;
    it.kind = kind;
    it.vec  = mk(kind, ch, k);
    sb.push_back(it);
  endtask

  task automatic push_session(input logic [3:0] mask, input int n, input int passes);
    for (int p = 0; p < passes; p++) begin
      for (int ch = 0; ch < 4; ch++) begin
        if (mask[ch]) begin
          push(K_SEL, 0, 0);
          push(K_INIT, ch, 0);
          for (int k = 0; k < n; k++) push(K_RUN, ch, k);
        end
      end
      push(K_SEL, 0, 0);
      push(K_FIN, 0, 0);
    end
  endtask

  task automatic launch(input int n, input logic [3:0] mask);
    start = 1'b0;
    @(posedge clk);
    #1;
    ncycles = 16'(n);
    ch_mask = mask;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    ncycles = 16'($urandom_range(0, 65535));
    ch_mask = 4'($urandom_range(0, 15));
  endtask

  // Pop one expected item per cycle after accept; hooks drive abort/start/loop at chosen items.
  task automatic drain(input int abort_idx, input int start_idx, input int loop_keep,
                       input int period, output int cycles);
    item_t e;
    int    idx = 0;
    int    fin_seen = 0;
    int    last_fin = -1;
    cycles = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      cycles++;
      e = sb.pop_front();
      if (loop_keep > 0) loop = (fin_seen < loop_keep);
      abort = (idx == abort_idx);
      if (idx == start_idx) start = 1'b1;
      check($sformatf("trace%0d", idx), {6'h0, pass_cnt, obs()}, {6'h0, 8'(fin_seen), e.vec});
      if (idx == 0) check("flags_clear", {aborted, bist_end}, 2'b00);
      if (e.kind == K_FIN) begin
        if (last_fin >= 0) check("fin_period", cycles - last_fin, period);
        last_fin = cycles;
        fin_seen++;
      end
      idx++;
    end
    abort = 1'b0;
  endtask

  task automatic end_check(input int cycles, input int lat, input int pc, input logic ab);
    @(negedge clk);
    check("idle_end", obs(), {1'b1, 25'h0});
    check("latency", cycles + 1, lat);
    check("pass_cnt", pass_cnt, pc);
    check("aborted", aborted, ab);
  endtask

  initial begin
    int e;
    // Reset with start held high.
    #3;
    check("rst_out", {pass_cnt, aborted, obs(), cycle_cnt}, '0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("held_start", busy, 1'b0);
    end

    // Two channels, three RUN cycles each.
    launch(3, 4'b0101);
    push_session(4'b0101, 3, 1);
    drain(-1, -1, 0, 12, cyc);
    e = $countones(4'b0101);
    end_check(cyc, e * (3 + 2) + 3, 1, 1'b0);

    // Zero RUN cycles, all channels.
    launch(0, 4'b1111);
    push_session(4'b1111, 0, 1);
    drain(-1, -1, 0, 10, cyc);
    end_check(cyc, 4 * 2 + 3, 1, 1'b0);

    // Loop mode for three passes, then a final pass to IDLE.
    loop = 1'b1;
    launch(2, 4'b0010);
    push_session(4'b0010, 2, 4);
    drain(-1, -1, 3, 1 * (2 + 2) + 2, cyc);
    end_check(cyc, 4 * (1 * (2 + 2) + 2) + 1, 4, 1'b0);
    loop = 1'b0;

    // Abort on second RUN cycle of channel 0, with loop requested.
    loop = 1'b1;
    launch(3, 4'b0101);
    push(K_SEL, 0, 0);
    push(K_INIT, 0, 0);
    push(K_RUN, 0, 0);
    push(K_RUN, 0, 1);
    push(K_FIN, 0, 0);
    drain(3, -1, 0, 0, cyc);
    end_check(cyc, 6, 0, 1'b1);
    loop = 1'b0;

    // New start clears flags; empty mask goes straight to FINISH.
    launch(0, 4'b0000);
    push_session(4'b0000, 0, 1);
    drain(-1, -1, 0, 2, cyc);
    end_check(cyc, 3, 1, 1'b0);

    // Start edge during RUN is ignored; reset mid-session clears everything at once.
    launch(6, 4'b0001);
    push(K_SEL, 0, 0);
    push(K_INIT, 0, 0);
    for (int k = 0; k < 5; k++) push(K_RUN, 0, k);
    drain(-1, 3, 0, 0, cyc);
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid", {pass_cnt, aborted, obs(), cycle_cnt}, '0);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
